// File: rtl/frame_block_gen_pkg.sv
// Shared frame-generator constants: 64b/66b block types, sync headers
// and the frame FSM state encoding.
package frame_block_gen_pkg;

  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_TERM  = 8'h87;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int unsigned CNT_W = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IPG   = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_TERM  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_block_gen.sv
// Synthetic 64b/66b frame source: idle gap, start, data, terminate,
// with frame shape taken from the upstream PRBS word at each TERM.
module frame_block_gen
  import frame_block_gen_pkg::*;
#(
  parameter int unsigned MIN_DATA = 2,
  parameter int unsigned MIN_IPG  = 1,
  parameter int unsigned PRBS_W   = 12
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [PRBS_W-1:0] i_prbs,
  output logic              o_prbs_req,
  output logic [65:0]       o_block,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_frame_cnt
);

  localparam cnt_t MIN_DATA_C = cnt_t'(MIN_DATA);
  localparam cnt_t MIN_IPG_C  = cnt_t'(MIN_IPG);

  state_e      state_q, state_d;
  cnt_t        ipg_q, ipg_d;
  cnt_t        len_q, len_d;
  cnt_t        dcnt_q, dcnt_d;
  logic [63:0] pay_q, pay_d;
  logic [31:0] frame_q, frame_d;
  logic [65:0] blk_q, blk_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        load;
  logic        unused_prbs;

  // only the two low nibbles shape the frame
  assign unused_prbs = ^i_prbs;

  assign load = i_enable && (!valid_q || i_ready);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IPG;
      ipg_q   <= MIN_IPG_C;
      len_q   <= MIN_DATA_C;
      dcnt_q  <= '0;
      pay_q   <= '0;
      frame_q <= '0;
      blk_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ipg_q   <= ipg_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      pay_q   <= pay_d;
      frame_q <= frame_d;
      blk_q   <= blk_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ipg_d   = ipg_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    pay_d   = pay_q;
    frame_d = frame_q;
    if (load) begin
      unique case (state_q)
        S_IPG: begin
          ipg_d = ipg_q - cnt_t'(1);
          if (ipg_q <= cnt_t'(1)) state_d = S_START;
        end
        S_START: begin
          dcnt_d  = len_q;
          state_d = S_DATA;
        end
        S_DATA: begin
          pay_d  = pay_q + 64'd1;
          dcnt_d = dcnt_q - cnt_t'(1);
          if (dcnt_q <= cnt_t'(1)) state_d = S_TERM;
        end
        S_TERM: begin
          len_d   = MIN_DATA_C + cnt_t'(i_prbs[3:0]);
          ipg_d   = MIN_IPG_C + cnt_t'(i_prbs[7:4]);
          frame_d = frame_q + 32'd1;
          state_d = S_IPG;
        end
        default: state_d = S_IPG;
      endcase
    end
  end

  always_comb begin
    blk_d   = blk_q;
    valid_d = valid_q;
    req_d   = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      req_d   = (state_q == S_TERM);
      unique case (state_q)
        S_IPG:   blk_d = {SYNC_CTRL, 56'h0, BT_IDLE};
        S_START: blk_d = {SYNC_CTRL, pay_q[55:0], BT_START};
        S_DATA:  blk_d = {SYNC_DATA, pay_q};
        S_TERM:  blk_d = {SYNC_CTRL, 56'h0, BT_TERM};
        default: blk_d = {SYNC_CTRL, 56'h0, BT_IDLE};
      endcase
    end else if (valid_q && i_ready) begin
      // held block taken while disabled: go idle until re-enabled
      valid_d = 1'b0;
    end
  end

  assign o_block     = blk_q;
  assign o_valid     = valid_q;
  assign o_prbs_req  = req_q;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_block_gen.sv
// Self-checking bench for frame_block_gen: vector table, directed
// corner sequences and a randomized run against a frame-level model.
module tb_frame_block_gen;

  logic        clk = 1'b0;
  logic        rst, en, rdy;
  logic [11:0] prbs;
  logic        req, vld;
  logic [65:0] blk;
  logic [31:0] fc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  frame_block_gen dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .i_prbs     (prbs),
    .o_prbs_req (req),
    .o_block    (blk),
    .o_valid    (vld),
    .i_ready    (rdy),
    .o_frame_cnt(fc)
  );

  typedef struct {
    logic        r, e, y;
    logic [11:0] p;
    logic        v;
    logic [65:0] b;
    logic        q;
    logic [31:0] f;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [65:0] b_idle();
    return {2'b10, 56'h0, 8'h1E};
  endfunction
  function automatic logic [65:0] b_start(logic [63:0] p);
    return {2'b10, p[55:0], 8'h78};
  endfunction
  function automatic logic [65:0] b_data(logic [63:0] p);
    return {2'b01, p};
  endfunction
  function automatic logic [65:0] b_term();
    return {2'b10, 56'h0, 8'h87};
  endfunction

  function automatic vec_t mk(logic r, logic e, logic y, logic [11:0] p,
                              logic v, logic [65:0] b, logic q,
                              logic [31:0] f);
    vec_t t;
    t.r = r; t.e = e; t.y = y; t.p = p;
    t.v = v; t.b = b; t.q = q; t.f = f;
    return t;
  endfunction

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset(logic [11:0] p);
    rst = 1'b1; en = 1'b1; rdy = 1'b1; prbs = p;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // frame-level reference model for the random run
  logic [65:0] exp_q[$];
  logic [11:0] words[256];
  int          frame_k;
  logic [63:0] mpay;

  function automatic void gen_frame();
    int nidle, ndata;
    nidle = (frame_k == 0) ? 1 : 1 + int'(words[frame_k-1][7:4]);
    ndata = (frame_k == 0) ? 2 : 2 + int'(words[frame_k-1][3:0]);
    for (int i = 0; i < nidle; i++) exp_q.push_back(b_idle());
    exp_q.push_back(b_start(mpay));
    for (int i = 0; i < ndata; i++) begin
      exp_q.push_back(b_data(mpay));
      mpay = mpay + 64'd1;
    end
    exp_q.push_back(b_term());
    frame_k++;
  endfunction

  initial begin
    logic [65:0] hold, eb;
    int terms, nd0, nd, ni, widx, pulses, tacc;
    logic pv, pr;
    logic [65:0] pb;

    rst = 1'b1; en = 1'b0; rdy = 1'b1; prbs = '0;

    // ---- table: reset then two frames with prbs = 0
    tbl[0]  = mk(1, 1, 1, 12'h0, 0, 66'h0,      0, 0);
    tbl[1]  = mk(0, 1, 1, 12'h0, 1, b_idle(),   0, 0);
    tbl[2]  = mk(0, 1, 1, 12'h0, 1, b_start(0), 0, 0);
    tbl[3]  = mk(0, 1, 1, 12'h0, 1, b_data(0),  0, 0);
    tbl[4]  = mk(0, 1, 1, 12'h0, 1, b_data(1),  0, 0);
    tbl[5]  = mk(0, 1, 1, 12'h0, 1, b_term(),   1, 1);
    tbl[6]  = mk(0, 1, 1, 12'h0, 1, b_idle(),   0, 1);
    tbl[7]  = mk(0, 1, 1, 12'h0, 1, b_start(2), 0, 1);
    tbl[8]  = mk(0, 1, 1, 12'h0, 1, b_data(2),  0, 1);
    tbl[9]  = mk(0, 1, 1, 12'h0, 1, b_data(3),  0, 1);
    tbl[10] = mk(0, 1, 1, 12'h0, 1, b_term(),   1, 2);
    tbl[11] = mk(0, 1, 1, 12'h0, 1, b_idle(),   0, 2);
    cyc();
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; en = tbl[i].e; rdy = tbl[i].y; prbs = tbl[i].p;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 80'(vld), 80'(tbl[i].v));
      chk($sformatf("tbl%0d_block", i), 80'(blk), 80'(tbl[i].b));
      chk($sformatf("tbl%0d_req", i),   80'(req), 80'(tbl[i].q));
      chk($sformatf("tbl%0d_fcnt", i),  80'(fc),  80'(tbl[i].f));
    end

    // ---- prbs 0F3 latched at TERM: 16 idles then 5 data blocks
    do_reset(12'h0F3);
    terms = 0; nd0 = 0; nd = 0; ni = 0;
    for (int c = 0; c < 200 && terms < 2; c++) begin
      cyc();
      if (vld) begin
        if (blk == b_term()) terms++;
        else if (terms == 1 && blk[65:64] == 2'b01) nd++;
        else if (terms == 1 && blk == b_idle()) ni++;
        else if (terms == 0 && blk[65:64] == 2'b01) nd0++;
      end
    end
    chk("f0f3_terms", 80'(terms), 80'(2));
    chk("f0f3_first_data", 80'(nd0), 80'(2));
    chk("f0f3_idles", 80'(ni), 80'(16));
    chk("f0f3_data", 80'(nd), 80'(5));

    // ---- stall during DATA and across TERM
    do_reset(12'h000);
    cyc(); cyc(); cyc();
    chk("stall_pre", 80'(blk), 80'(b_data(0)));
    hold = blk;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_data_blk", 80'({vld, blk}), 80'({1'b1, hold}));
      chk("stall_data_req", 80'(req), 80'(0));
    end
    rdy = 1'b1;
    cyc();
    chk("stall_resume", 80'(blk), 80'(b_data(1)));
    cyc();
    chk("term_req", 80'({req, blk}), 80'({1'b1, b_term()}));
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_term_blk", 80'({vld, blk}), 80'({1'b1, b_term()}));
      chk("stall_term_req", 80'(req), 80'(0));
      chk("stall_term_fc", 80'(fc), 80'(1));
    end
    rdy = 1'b1;
    cyc();
    chk("after_term", 80'({req, blk}), 80'({1'b0, b_idle()}));

    // ---- enable dropped during DATA
    do_reset(12'h000);
    cyc(); cyc(); cyc();
    chk("en_pre", 80'(blk), 80'(b_data(0)));
    en = 1'b0;
    cyc();
    chk("en_drop1", 80'(vld), 80'(0));
    cyc();
    chk("en_drop2", 80'(vld), 80'(0));
    en = 1'b1;
    cyc();
    chk("en_resume", 80'({vld, blk}), 80'({1'b1, b_data(1)}));

    // ---- reset for one cycle mid-DATA
    do_reset(12'h000);
    for (int i = 0; i < 8; i++) cyc();
    chk("mid_pre", 80'({fc, blk}), 80'({32'd1, b_data(2)}));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst", 80'({vld, req, fc, blk}), 80'(0));
    cyc();
    chk("mid_idle", 80'({vld, blk}), 80'({1'b1, b_idle()}));
    cyc();
    chk("mid_start", 80'(blk), 80'(b_start(0)));
    cyc();
    chk("mid_data0", 80'({fc, blk}), 80'({32'd0, b_data(0)}));

    // ---- pay_cnt wrap through a forced preload
    rst = 1'b1; en = 1'b0; rdy = 1'b1; prbs = '0;
    cyc();
    rst = 1'b0;
    force dut.pay_q = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    release dut.pay_q;
    en = 1'b1;
    cyc();
    chk("wrap_idle", 80'(blk), 80'(b_idle()));
    cyc();
    chk("wrap_start", 80'(blk), 80'(b_start(64'hFFFF_FFFF_FFFF_FFFF)));
    cyc();
    chk("wrap_d0", 80'(blk), 80'(b_data(64'hFFFF_FFFF_FFFF_FFFF)));
    cyc();
    chk("wrap_d1", 80'(blk), 80'(b_data(64'h0)));
    cyc();
    chk("wrap_term", 80'(blk), 80'(b_term()));

    // ---- randomized run against the frame model
    for (int i = 0; i < 256; i++) words[i] = 12'($urandom);
    exp_q.delete();
    frame_k = 0; mpay = '0; widx = 0; pulses = 0; tacc = 0;
    do_reset(words[0]);
    pv = 1'b0; pr = 1'b1; pb = '0;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (pv && !pr)
        chk("rnd_hold", 80'({vld, blk}), 80'({1'b1, pb}));
      if (req) begin
        chk("rnd_req_term", 80'({vld, blk}), 80'({1'b1, b_term()}));
        pulses++;
        if (widx < 255) widx++;
        prbs = words[widx];
      end
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (vld && rdy) begin
        if (exp_q.size() == 0) gen_frame();
        eb = exp_q.pop_front();
        chk("rnd_block", 80'(blk), 80'(eb));
        if (eb == b_term()) begin
          tacc++;
          chk("rnd_fcnt", 80'(fc), 80'(tacc));
          chk("rnd_pulses", 80'(pulses), 80'(tacc));
        end
      end
      pv = vld; pr = rdy; pb = blk;
    end
    chk("rnd_frames_seen", 80'(tacc > 20), 80'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_block_gen.md
# frame_block_gen

Synthetic 64b/66b frame source for the frame generator. It builds a continuous stream of 66-bit blocks shaped as idle gap, start, data, and terminate. Data-block count and idle-gap length per frame come from the upstream 12-bit PRBS word. The block sits directly downstream of the PRBS generator, drives that generator's advance strobe, and feeds the PCS transmit path through a valid/ready handshake.

## Interface
- MIN_DATA, 2: minimum data blocks per frame.
- MIN_IPG, 1: minimum idle blocks between frames.
- PRBS_W, 12: width of the PRBS input word. Must be at least 8.
- i_clock, in, 1: clock.
- i_reset, in, 1: reset. Synchronous, active-high.
- i_enable, in, 1: run enable. Low means no new block is loaded; the held block is kept.
- i_prbs, in, PRBS_W: current PRBS word, bits [3:0] and [7:4] used.
- o_prbs_req, out, 1: one-cycle advance pulse. Drives the PRBS i_enable/i_valid.
- o_block, out, 66: {sync[65:64], payload[63:0]}.
- o_valid, out, 1: o_block is valid.
- i_ready, in, 1: downstream accepts o_block when o_valid is high.
- o_frame_cnt, out, 32: count of completed frames. Wraps.

## Operation
- FSM states: S_IPG, S_START, S_DATA, S_TERM.
- Reset values:
  - FSM: S_IPG, with ipg_cnt=MIN_IPG and data_len=MIN_DATA.
  - Payload counter: 0.
  - Outputs: o_frame_cnt=0, o_valid=0, o_block=66'h0, o_prbs_req=0.
- Load condition, `load = i_enable && (!o_valid || i_ready)`. When load is true, the output register takes the block for the current state and the FSM advances. Otherwise o_block, o_valid and the FSM hold.
- Block contents (block type sits in payload[7:0]):
  - S_IPG: sync 2'b10, payload {56'h0, 8'h1E}. Decrement ipg_cnt. Go to S_START once MIN_IPG+… idles have been emitted, i.e. when ipg_cnt reaches 1.
  - S_START: sync 2'b10, payload {pay_cnt[55:0], 8'h78}. Set data_cnt=data_len. Go to S_DATA.
  - S_DATA: sync 2'b01, payload pay_cnt[63:0]. Increment pay_cnt and decrement data_cnt. Go to S_TERM when data_cnt reaches 1.
  - S_TERM: sync 2'b10, payload {56'h0, 8'h87}. Then:
    - latch data_len = MIN_DATA + i_prbs[3:0] and ipg_cnt = MIN_IPG + i_prbs[7:4];
    - pulse o_prbs_req for exactly this one cycle;
    - increment o_frame_cnt;
    - go to S_IPG.
- pay_cnt is 64 bits, wraps modulo 2^64, and is not reset per frame.
- The START payload carries the pay_cnt value that the first DATA block will carry.
- Counter widths: data_len, data_cnt, ipg_cnt are 5 bits each.
- When i_enable=0 and o_valid=1: o_block stays valid until accepted. After acceptance o_valid falls to 0 and remains 0 until i_enable returns.

## Timing
- Registered outputs, so blocks update one cycle after the load cycle.
- First valid block: o_valid=1 on the first cycle after reset deasserts, provided i_enable=1. That block is an idle.
- Throughput is one block per cycle while i_ready=1.
- o_prbs_req is registered high in the cycle the TERM block is loaded. The PRBS word therefore advances exactly once per frame. The values latched for the next frame are the i_prbs value present on that load cycle.
- Stall (i_ready=0 with o_valid=1): no load, no o_prbs_req, no counter change.
- Reset mid-frame: the next cycle shows reset values. The partial frame is dropped and not counted. The next block after reset is an idle.
- Frame length from START through TERM is data_len+2 blocks.
- Gap length is ipg_cnt idle blocks, except after reset, where it is MIN_IPG.

## Structure
- Shared frame-generator package holds:
  - block-type constants: IDLE 8'h1E, START 8'h78, TERM 8'h87;
  - sync constants: SYNC_DATA 2'b01, SYNC_CTRL 2'b10;
  - the FSM state encoding.
- Single flat module. No sub-module is needed; the PRBS generator is instantiated by the parent alongside this block.

## Test plan
- Reset, then i_enable=1, i_ready=1, i_prbs=12'h000:
  - blocks are 1 idle, then START {56'h0,78}, then DATA 0, DATA 1, then TERM;
  - o_prbs_req pulses once, with TERM;
  - o_frame_cnt becomes 1.
- i_prbs=12'h0F3 sampled at TERM: the next frame has 5 DATA blocks, preceded by 16 idles.
- i_ready held 0 for 4 cycles during DATA: o_block is stable, pay_cnt is unchanged, and o_prbs_req stays 0 even if the stall covers TERM.
- i_enable dropped during DATA: the current block is accepted, then o_valid goes 0. On re-enable the stream resumes with the next DATA value and no gap in pay_cnt.
- i_reset asserted for one cycle mid-DATA:
  - all outputs return to reset values;
  - the first block after reset is an idle;
  - pay_cnt restarts at 0;
  - o_frame_cnt=0.
- pay_cnt preloaded near 64'hFFFF_FFFF_FFFF_FFFF through a force: it wraps to 0 across consecutive DATA blocks with no glitch in sync.
